// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter that feeds one UART transmitter one frame at a time.
// Define TX_TIMEOUT_EN to abort a frame whose TX_Busy never rises within TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic [DATA_WIDTH-1:0] DATA0,
  output logic                  ACK0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] DATA1,
  output logic                  ACK1,
  input  logic                  TX_Busy,
  output logic                  TX_Data_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic [1:0]            GNT,
  output logic                  ERR
);

  // state     | meaning
  // IDLE      | no frame owned; grant when a request is up and TX_Busy is low
  // ISSUE     | payload captured; strobe TX_Data_Valid next cycle
  // WAIT_BUSY | waiting for the transmitter to raise TX_Busy
  // WAIT_DONE | frame in flight; wait for TX_Busy to fall
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state, state_nx;
  logic                  rr_last, rr_last_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic [1:0]            gnt_nx;
  logic                  ack0_nx, ack1_nx, valid_nx;
  logic                  win1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win1 = REQ1 && (!REQ0 || !rr_last);

`ifdef TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmr, tmr_nx;
  logic          err_nx;
`endif

  always_comb begin
    state_nx   = state;
    rr_last_nx = rr_last;
    data_nx    = TX_P_DATA;
    gnt_nx     = GNT;
    ack0_nx    = 1'b0;
    ack1_nx    = 1'b0;
    valid_nx   = 1'b0;
`ifdef TX_TIMEOUT_EN
    tmr_nx     = tmr;
    err_nx     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if ((REQ0 || REQ1) && !TX_Busy) begin
          data_nx    = win1 ? DATA1 : DATA0;
          gnt_nx     = win1 ? 2'b10 : 2'b01;
          ack0_nx    = !win1;
          ack1_nx    = win1;
          rr_last_nx = win1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        valid_nx = 1'b1;
        state_nx = WAIT_BUSY;
`ifdef TX_TIMEOUT_EN
        tmr_nx   = TW'(TIMEOUT - 1);
`endif
      end
      WAIT_BUSY: begin
        if (TX_Busy) begin
          state_nx = WAIT_DONE;
        end
`ifdef TX_TIMEOUT_EN
        else if (tmr == '0) begin
          err_nx   = 1'b1;
          gnt_nx   = 2'b00;
          state_nx = IDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!TX_Busy) begin
          gnt_nx   = 2'b00;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      rr_last       <= 1'b1;
      TX_P_DATA     <= '0;
      GNT           <= 2'b00;
      ACK0          <= 1'b0;
      ACK1          <= 1'b0;
      TX_Data_Valid <= 1'b0;
    end else begin
      state         <= state_nx;
      rr_last       <= rr_last_nx;
      TX_P_DATA     <= data_nx;
      GNT           <= gnt_nx;
      ACK0          <= ack0_nx;
      ACK1          <= ack1_nx;
      TX_Data_Valid <= valid_nx;
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmr <= '0;
      ERR <= 1'b0;
    end else begin
      tmr <= tmr_nx;
      ERR <= err_nx;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a transmitter model drives TX_Busy, a monitor
// checks every ACK / TX_Data_Valid against a queue of expected frames.
module tb_uart_tx_arbiter;
  localparam int DW    = 8;
  localparam int FRAME = 6;

  logic          CLK = 1'b0, RST = 1'b0;
  logic          REQ0 = 1'b0, REQ1 = 1'b0;
  logic [DW-1:0] DATA0 = '0, DATA1 = '0;
  logic          ACK0, ACK1, TX_Busy, TX_Data_Valid, ERR;
  logic [DW-1:0] TX_P_DATA;
  logic [1:0]    GNT;

  logic model_busy = 1'b0, force_busy = 1'b0, no_resp = 1'b0;
  assign TX_Busy = model_busy | force_busy;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .DATA0(DATA0), .ACK0(ACK0),
    .REQ1(REQ1), .DATA1(DATA1), .ACK1(ACK1),
    .TX_Busy(TX_Busy), .TX_Data_Valid(TX_Data_Valid),
    .TX_P_DATA(TX_P_DATA), .GNT(GNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic owner; logic [DW-1:0] data;} exp_t;
  exp_t sb_q[$];

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic owner, input logic [DW-1:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  // Transmitter: TX_Busy seen by the DUT two edges after TX_Data_Valid, high for FRAME cycles.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (TX_Data_Valid && !no_resp) begin
        @(posedge CLK); #1;
        model_busy = 1'b1;
        repeat (FRAME) @(posedge CLK);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int            cyc = 0;
    int            ack_cyc = -100;
    logic          pa = 1'b0, pv = 1'b0;
    logic [DW-1:0] last_data = '0;
    exp_t          e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST) begin
        pa = 1'b0;
        pv = 1'b0;
        continue;
      end
      if (ACK0 || ACK1) begin
        check("ack_not_consecutive", pa, 0);
        check("ack_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("ack_owner", {ACK1, ACK0}, e.owner ? 2'b10 : 2'b01);
          check("ack_data", TX_P_DATA, e.data);
          check("ack_gnt", GNT, e.owner ? 2'b10 : 2'b01);
          last_data = e.data;
        end
        ack_cyc = cyc;
      end
      if (TX_Data_Valid) begin
        check("valid_not_consecutive", pv, 0);
        check("valid_latency", cyc - ack_cyc, 1);
        check("valid_data", TX_P_DATA, last_data);
      end
      pa = ACK0 | ACK1;
      pv = TX_Data_Valid;
    end
  end

  task automatic wait_ack();
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (ACK0 || ACK1) begin
        got = 1;
        break;
      end
    end
    check("wait_ack", got, 1);
  endtask

  task automatic wait_busy(input logic lvl);
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (TX_Busy == lvl) begin
        got = 1;
        break;
      end
    end
    check("wait_busy", got, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack0"}, ACK0, 0);
    check({tag, "_ack1"}, ACK1, 0);
    check({tag, "_valid"}, TX_Data_Valid, 0);
    check({tag, "_gnt"}, GNT, 0);
    check({tag, "_pdata"}, TX_P_DATA, 0);
    check({tag, "_err"}, ERR, 0);
  endtask

  initial begin
    int early;
    int k;
    int cnt;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Tie from reset: 11, 22, 11.
    DATA0 = 8'h11; DATA1 = 8'h22; REQ0 = 1'b1; REQ1 = 1'b1;
    push(1'b0, 8'h11); push(1'b1, 8'h22); push(1'b0, 8'h11);
    repeat (3) wait_ack();
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_busy(1'b1); wait_busy(1'b0);
    repeat (3) @(negedge CLK);

    // Single requester 0.
    DATA0 = 8'hA5; REQ0 = 1'b1;
    push(1'b0, 8'hA5);
    wait_ack();
    REQ0 = 1'b0;
    check("single_gnt", GNT, 2'b01);
    wait_busy(1'b1); wait_busy(1'b0);
    @(negedge CLK);
    check("single_gnt_cleared", GNT, 2'b00);
    repeat (2) @(negedge CLK);

    // Requester 1 arrives during WAIT_DONE of a requester 0 frame.
    DATA0 = 8'h5A; REQ0 = 1'b1;
    push(1'b0, 8'h5A);
    wait_ack();
    REQ0 = 1'b0;
    wait_busy(1'b1);
    DATA1 = 8'hC3; REQ1 = 1'b1;
    push(1'b1, 8'hC3);
    early = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (ACK1) early++;
      if (!TX_Busy) break;
    end
    check("no_ack1_in_wait_done", early, 0);
    check("busy_fell", TX_Busy, 0);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (ACK1) begin
        k = i;
        break;
      end
    end
    check("ack1_latency", k, 2);
    REQ1 = 1'b0;
    wait_busy(1'b1); wait_busy(1'b0);
    repeat (2) @(negedge CLK);

    // Transmitter never responds.
    no_resp = 1'b1;
    DATA0 = 8'h77; REQ0 = 1'b1;
    push(1'b0, 8'h77);
    wait_ack();
    REQ0 = 1'b0;
`ifdef TX_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      cnt++;
      if (ERR) break;
    end
    check("err_latency", cnt, 17);
    check("err_gnt", GNT, 2'b00);
    @(negedge CLK);
    check("err_single_pulse", ERR, 0);
`else
    cnt = 0;
    repeat (40) begin
      @(negedge CLK);
      if (ERR) cnt++;
    end
    check("no_err_without_timeout", cnt, 0);
    check("stuck_gnt", GNT, 2'b01);
    force_busy = 1'b1;
    repeat (3) @(negedge CLK);
    force_busy = 1'b0;
    repeat (2) @(negedge CLK);
    check("recovered_gnt", GNT, 2'b00);
`endif
    no_resp = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset during WAIT_DONE, then stale TX_Busy blocks the next grant.
    DATA0 = 8'h99; REQ0 = 1'b1;
    push(1'b0, 8'h99);
    wait_ack();
    REQ0 = 1'b0;
    wait_busy(1'b1);
    @(negedge CLK);
    RST = 1'b0; force_busy = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge CLK);
    RST = 1'b1;
    DATA0 = 8'h3C; REQ0 = 1'b1;
    early = 0;
    repeat (12) begin
      @(negedge CLK);
      if (ACK0 || ACK1) early++;
    end
    check("no_grant_while_busy", early, 0);
    push(1'b0, 8'h3C);
    force_busy = 1'b0;
    wait_ack();
    REQ0 = 1'b0;
    wait_busy(1'b1); wait_busy(1'b0);
    repeat (3) @(negedge CLK);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester's payload and of TX_P_DATA.
REQ-002 Parameter TIMEOUT, default 16: WAIT_BUSY cycle limit, used only when TX_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 REQ0  in  1  requester 0 request; held high until ACK0.
REQ-006 DATA0  in  DATA_WIDTH  requester 0 payload; stable while REQ0 is high.
REQ-007 ACK0  out  1  one-cycle pulse when DATA0 is captured.
REQ-008 REQ1, DATA1, ACK1  in/in/out  1/DATA_WIDTH/1  requester 1, same rules as requester 0.
REQ-009 TX_Busy  in  1  busy flag from the UART transmitter; registered, rises 2 cycles after TX_Data_Valid.
REQ-010 TX_Data_Valid  out  1  one-cycle frame-start strobe to the transmitter.
REQ-011 TX_P_DATA  out  DATA_WIDTH  registered payload to the transmitter.
REQ-012 GNT  out  2  one-hot owner of the current frame; 2'b00 when idle.
REQ-013 ERR  out  1  one-cycle pulse on frame timeout.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE: if any REQ is high, capture the winner's DATA into TX_P_DATA, set GNT, pulse the winner's ACK in the same edge, and go to ISSUE; otherwise stay in IDLE.
REQ-016 Arbitration: only one request high -> grant it; both high -> grant the requester not served last (round-robin pointer updated at each grant).
REQ-017 ISSUE: TX_Data_Valid=1 for exactly this one cycle; next state WAIT_BUSY unconditionally.
REQ-018 WAIT_BUSY: TX_Busy=1 -> WAIT_DONE; otherwise stay.
REQ-019 WAIT_DONE: TX_Busy=0 -> IDLE with GNT cleared; otherwise stay.
REQ-020 A new grant SHALL NOT occur before the previous frame's TX_Busy has fallen; minimum spacing between TX_Data_Valid pulses is 4 cycles plus the frame time.
REQ-021 REQ changes outside IDLE SHALL be ignored; a request dropped before its ACK is not served.
REQ-022 TX_P_DATA SHALL hold its value from capture until the next capture.
REQ-023 ACKx, TX_Data_Valid and ERR SHALL be registered outputs, glitch-free, and never high for two consecutive cycles.
REQ-024 TX_Busy high while in IDLE (a foreign or stale frame) SHALL block grants until TX_Busy is low.

Reset
REQ-025 RST low SHALL immediately force: state IDLE, round-robin pointer set so requester 0 wins the first tie, TX_P_DATA=0, GNT=0, ACK0=ACK1=0, TX_Data_Valid=0, ERR=0, timeout counter 0.
REQ-026 Reset mid-frame SHALL abandon the frame without any ACK or ERR; after release the FSM restarts from IDLE and obeys REQ-024.

Configuration
REQ-027 Macro TX_TIMEOUT_EN defined: a counter runs in WAIT_BUSY; TX_Busy still low after TIMEOUT cycles -> pulse ERR, clear GNT, go to IDLE (payload already ACKed, so it is dropped).
REQ-028 Macro TX_TIMEOUT_EN undefined: no counter is built, ERR is tied 0, and WAIT_BUSY waits indefinitely; the port list is identical in both builds.

Verification
REQ-029 REQ0=1 with DATA0=8'hA5, REQ1=0 -> ACK0 pulses, GNT=01, TX_P_DATA=A5, TX_Data_Valid pulses one cycle later, GNT=00 after TX_Busy falls.
REQ-030 REQ0 and REQ1 held high together with DATA 8'h11 and 8'h22 for three frames after reset -> frames sent in order 11, 22, 11.
REQ-031 REQ1 rises during WAIT_DONE of a requester 0 frame -> no ACK1 until IDLE; then ACK1 is issued the cycle after TX_Busy falls.
REQ-032 TX_Busy held low after ISSUE with TX_TIMEOUT_EN defined and TIMEOUT=16 -> ERR pulses at cycle 16 of WAIT_BUSY and GNT=00; same stimulus without the macro -> FSM stays in WAIT_BUSY and ERR stays 0.
REQ-033 RST asserted during WAIT_DONE -> all outputs 0 immediately; after release with TX_Busy=1 and REQ0=1 -> no grant until TX_Busy=0.
